ucaspian_step_ctrl: RTL and testbench

Timestep sequencer for the uCaspian core: accepts host commands (run N steps, clear activity, clear configuration) and drives the shared enable, next_step and clear_act/clear_config controls of the neuron/axon/synapse/dendrite units. Advances a step only when every unit reports step_done after a settle window. Sits between the host command decoder and the datapath units.

---
 rtl/ucaspian_step_ctrl.sv | 138 +++++++++++++
 tb/tb_ucaspian_step_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_step_ctrl.sv
// Timestep sequencer for the uCaspian core: runs N steps, clears activity/config,
// and gates host configuration to the idle state.
module ucaspian_step_ctrl #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned STEP_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           cmd,
    input  logic [STEP_W-1:0]    cmd_steps,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 abort,
    input  logic [NUM_UNITS-1:0] unit_step_done,
    input  logic [NUM_UNITS-1:0] unit_clear_done,
    output logic                 enable,
    output logic                 next_step,
    output logic                 clear_act,
    output logic                 clear_config,
    output logic                 config_allow,
    output logic                 step_pulse,
    output logic [STEP_W-1:0]    time_count,
    output logic                 cmd_done,
    output logic                 busy
);

    localparam int unsigned SET_W = 4;
    localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYC);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN_START,
        RUN_WAIT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [SET_W-1:0]   settle, settle_nxt;
    logic [STEP_W-1:0]  remaining, remaining_nxt;
    logic [STEP_W-1:0]  time_nxt;
    logic               clr_cfg, clr_cfg_nxt;
    logic               step_nxt;
    logic               done_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state, counter updates and pulse requests.
    always_comb begin
        state_nxt     = state;
        settle_nxt    = settle;
        remaining_nxt = remaining;
        time_nxt      = time_count;
        clr_cfg_nxt   = clr_cfg;
        step_nxt      = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    case (cmd)
                        2'd0: done_nxt = 1'b1;
                        2'd1: begin
                            remaining_nxt = cmd_steps;
                            state_nxt     = (cmd_steps == '0) ? DONE : RUN_START;
                        end
                        default: begin
                            clr_cfg_nxt = (cmd == 2'd3);
                            settle_nxt  = '0;
                            state_nxt   = CLEAR;
                        end
                    endcase
                end
            end
            CLEAR: begin
                if (settle < SETTLE_MAX) settle_nxt = settle + SET_W'(1);
                if ((settle >= SETTLE_MAX) && (&unit_clear_done)) begin
                    time_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            RUN_START: begin
                settle_nxt = '0;
                state_nxt  = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (settle != SETTLE_MAX) begin
                    settle_nxt = settle + SET_W'(1);
                end else if (&unit_step_done) begin
                    step_nxt      = 1'b1;
                    time_nxt      = time_count + STEP_W'(1);
                    remaining_nxt = remaining - STEP_W'(1);
                    state_nxt     = ((remaining == STEP_W'(1)) || abort) ? DONE : RUN_START;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == DONE) done_nxt = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle       <= '0;
            remaining    <= '0;
            time_count   <= '0;
            clr_cfg      <= 1'b0;
            cmd_rdy      <= 1'b1;
            config_allow <= 1'b1;
            enable       <= 1'b0;
            next_step    <= 1'b0;
            clear_act    <= 1'b0;
            clear_config <= 1'b0;
            step_pulse   <= 1'b0;
            cmd_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            settle       <= settle_nxt;
            remaining    <= remaining_nxt;
            time_count   <= time_nxt;
            clr_cfg      <= clr_cfg_nxt;
            cmd_rdy      <= (state_nxt == IDLE);
            config_allow <= (state_nxt == IDLE);
            enable       <= (state_nxt == RUN_START) || (state_nxt == RUN_WAIT);
            next_step    <= (state_nxt == RUN_START);
            clear_act    <= (state_nxt == CLEAR) && !clr_cfg_nxt;
            clear_config <= (state_nxt == CLEAR) && clr_cfg_nxt;
            step_pulse   <= step_nxt;
            cmd_done     <= done_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ucaspian_step_ctrl.sv
// Directed self-checking bench for ucaspian_step_ctrl, including a narrow-counter
// instance used to exercise time_count wrap-around.
module tb_ucaspian_step_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cmd;
    logic [15:0] cmd_steps;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        abort;
    logic [3:0]  unit_step_done;
    logic [3:0]  unit_clear_done;
    logic        enable, next_step, clear_act, clear_config, config_allow;
    logic        step_pulse, cmd_done, busy;
    logic [15:0] time_count;

    logic [1:0]  w_cmd;
    logic [3:0]  w_cmd_steps;
    logic        w_cmd_vld, w_cmd_rdy;
    logic        w_enable, w_next_step, w_clear_act, w_clear_config, w_config_allow;
    logic        w_step_pulse, w_cmd_done, w_busy;
    logic [3:0]  w_time_count;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int ns_cnt, sp_cnt, cd_cnt, ca_cnt;
    int ns_cyc [0:7];

    always #5 clk = ~clk;

    ucaspian_step_ctrl #(.NUM_UNITS(4), .SETTLE_CYC(3), .STEP_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_steps(cmd_steps),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .abort(abort),
        .unit_step_done(unit_step_done), .unit_clear_done(unit_clear_done),
        .enable(enable), .next_step(next_step), .clear_act(clear_act),
        .clear_config(clear_config), .config_allow(config_allow),
        .step_pulse(step_pulse), .time_count(time_count), .cmd_done(cmd_done),
        .busy(busy)
    );

    ucaspian_step_ctrl #(.NUM_UNITS(2), .SETTLE_CYC(1), .STEP_W(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .cmd(w_cmd), .cmd_steps(w_cmd_steps),
        .cmd_vld(w_cmd_vld), .cmd_rdy(w_cmd_rdy), .abort(1'b0),
        .unit_step_done(2'b11), .unit_clear_done(2'b11),
        .enable(w_enable), .next_step(w_next_step), .clear_act(w_clear_act),
        .clear_config(w_clear_config), .config_allow(w_config_allow),
        .step_pulse(w_step_pulse), .time_count(w_time_count), .cmd_done(w_cmd_done),
        .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and tally the main instance's pulses just after the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
        cyc++;
        if (next_step) begin
            if (ns_cnt < 8) ns_cyc[ns_cnt] = cyc;
            ns_cnt++;
        end
        if (step_pulse) sp_cnt++;
        if (cmd_done)   cd_cnt++;
        if (clear_act)  ca_cnt++;
    endtask

    task automatic clr_counts();
        ns_cnt = 0; sp_cnt = 0; cd_cnt = 0; ca_cnt = 0;
        for (int i = 0; i < 8; i++) ns_cyc[i] = 0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] n);
        cmd = c; cmd_steps = n; cmd_vld = 1'b1;
        step_clk();
        cmd_vld = 1'b0; cmd = 2'd0; cmd_steps = '0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (cd_cnt == 0 && n < max) begin
            step_clk();
            n++;
        end
        chk(tag, 32'(cd_cnt != 0), 32'd1);
    endtask

    task automatic w_run(input logic [3:0] n, input string tag);
        int k = 0;
        w_cmd = 2'd1; w_cmd_steps = n; w_cmd_vld = 1'b1;
        @(posedge clk); #1;
        w_cmd_vld = 1'b0;
        while (!w_cmd_done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 32'(w_cmd_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; cmd = '0; cmd_steps = '0; cmd_vld = 1'b0; abort = 1'b0;
        unit_step_done = '0; unit_clear_done = '0;
        w_cmd = '0; w_cmd_steps = '0; w_cmd_vld = 1'b0;
        clr_counts();
        repeat (3) step_clk();

        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst_config_allow", 32'(config_allow), 32'd1);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_time", 32'(time_count), 32'd0);
        reset_n = 1'b1;
        step_clk();

        // RUN 3 with all units done: steps 5 cycles apart.
        clr_counts();
        unit_step_done = 4'hF;
        issue(2'd1, 16'd3);
        chk("run3_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
        chk("run3_config_allow_low", 32'(config_allow), 32'd0);
        chk("run3_enable", 32'(enable), 32'd1);
        wait_done("run3_done_timeout", 60);
        chk("run3_enable_off", 32'(enable), 32'd0);
        step_clk(); step_clk();
        chk("run3_next_step_cnt", 32'(ns_cnt), 32'd3);
        chk("run3_step_pulse_cnt", 32'(sp_cnt), 32'd3);
        chk("run3_cmd_done_cnt", 32'(cd_cnt), 32'd1);
        chk("run3_time", 32'(time_count), 32'd3);
        chk("run3_gap1", 32'(ns_cyc[1] - ns_cyc[0]), 32'd5);
        chk("run3_gap2", 32'(ns_cyc[2] - ns_cyc[1]), 32'd5);
        chk("run3_idle", 32'(busy), 32'd0);

        // RUN 2 with unit 1 late by 10 cycles past the settle window.
        clr_counts();
        unit_step_done = 4'b1101;
        issue(2'd1, 16'd2);
        repeat (14) step_clk();
        chk("late_no_step_pulse", 32'(sp_cnt), 32'd0);
        chk("late_one_next_step", 32'(ns_cnt), 32'd1);
        unit_step_done = 4'hF;
        wait_done("late_done_timeout", 60);
        step_clk();
        chk("late_next_step_cnt", 32'(ns_cnt), 32'd2);
        chk("late_step_pulse_cnt", 32'(sp_cnt), 32'd2);
        chk("late_gap", 32'(ns_cyc[1] - ns_cyc[0]), 32'd15);
        chk("late_time", 32'(time_count), 32'd5);

        // RUN 5 aborted during the second step.
        clr_counts();
        issue(2'd1, 16'd5);
        repeat (7) step_clk();
        abort = 1'b1;
        wait_done("abort_done_timeout", 60);
        abort = 1'b0;
        repeat (4) step_clk();
        chk("abort_next_step_cnt", 32'(ns_cnt), 32'd2);
        chk("abort_step_pulse_cnt", 32'(sp_cnt), 32'd2);
        chk("abort_cmd_done_cnt", 32'(cd_cnt), 32'd1);
        chk("abort_time", 32'(time_count), 32'd7);

        // RUN 0: finishes immediately, no step.
        clr_counts();
        issue(2'd1, 16'd0);
        chk("run0_cmd_done", 32'(cmd_done), 32'd1);
        chk("run0_next_step", 32'(next_step), 32'd0);
        step_clk();
        chk("run0_cmd_done_gone", 32'(cmd_done), 32'd0);
        chk("run0_busy", 32'(busy), 32'd0);
        chk("run0_ns_cnt", 32'(ns_cnt), 32'd0);
        chk("run0_time", 32'(time_count), 32'd7);

        // NOP: single cmd_done, stays idle.
        clr_counts();
        issue(2'd0, 16'd0);
        chk("nop_cmd_done", 32'(cmd_done), 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);

        // CLEAR_ACT with a stale all-done level still waits out the settle window.
        clr_counts();
        unit_clear_done = 4'hF;
        issue(2'd2, 16'd0);
        chk("clract_config_low", 32'(clear_config), 32'd0);
        wait_done("clract_done_timeout", 40);
        chk("clract_high_cycles", 32'(ca_cnt), 32'd4);
        chk("clract_time_zero", 32'(time_count), 32'd0);

        // CLEAR_CFG with staggered clear_done.
        clr_counts();
        unit_clear_done = 4'h0;
        step_clk();
        issue(2'd3, 16'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("clrcfg_held_%0d", i), 32'(clear_config), 32'd1);
            chk($sformatf("clrcfg_act_low_%0d", i), 32'(clear_act), 32'd0);
            case (i)
                0: unit_clear_done = 4'b0001;
                1: unit_clear_done = 4'b0011;
                2, 3: unit_clear_done = 4'b0111;
                default: unit_clear_done = 4'b1111;
            endcase
            step_clk();
        end
        chk("clrcfg_released", 32'(clear_config), 32'd0);
        chk("clrcfg_cmd_done", 32'(cmd_done), 32'd1);
        chk("clrcfg_time", 32'(time_count), 32'd0);

        // Narrow counter wraps 15 -> 0.
        w_run(4'd15, "wrap_run15_timeout");
        chk("wrap_time15", 32'(w_time_count), 32'd15);
        w_run(4'd1, "wrap_run1_timeout");
        chk("wrap_time0", 32'(w_time_count), 32'd0);

        // Asynchronous reset in the middle of RUN_WAIT.
        clr_counts();
        unit_step_done = 4'hF;
        issue(2'd1, 16'd3);
        repeat (7) step_clk();
        chk("midrst_time_before", 32'(time_count), 32'd1);
        chk("midrst_enable_before", 32'(enable), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_enable", 32'(enable), 32'd0);
        chk("midrst_next_step", 32'(next_step), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("midrst_time", 32'(time_count), 32'd0);
        step_clk();
        reset_n = 1'b1;
        step_clk();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
